fetch_stage: RTL and testbench

- Instruction-fetch stage of the multicycle processor, directly upstream of the controller and datapath decode.
- Holds the PC and runs a single-outstanding request/ready handshake to instruction memory.
- Captures each returned word into an IF/ID register and splits it into the opcode/funct3/funct7/register fields the controller consumes.
- Drives ihit, which tells the controller a valid instruction is present; honours downstream stall and branch/jump redirect.

---
 rtl/proc_pkg.sv | 26 ++
 rtl/ifid_reg.sv | 55 +++++
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the processor front end.
//  - RISC-V base opcode constants used by the controller decode
//  - NOP encoding (addi x0, x0, 0) loaded into IF/ID on reset and flush
//  - Default reset PC
//  - Fetch-stage state encoding
package proc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic {
        FETCH  = 1'b0,
        DECODE = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: holds the fetched instruction word, its PC and
// a valid flag.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   load         capture instr_in / pc_in and set valid
//   consume      clear valid only (word and PC remain visible)
//   flush        clear valid and replace the word with a NOP (highest priority)
//   instr_in     incoming instruction word
//   pc_in        PC of the incoming word
//   instr, pc    registered word and PC
//   valid        registered valid flag
module ifid_reg
    import proc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            consume,
    input  logic            flush,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic            valid
);

    logic [31:0]     instr_reg;
    logic [XLEN-1:0] pc_reg;
    logic            valid_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_reg <= NOP_INSTR;
            pc_reg    <= '0;
            valid_reg <= 1'b0;
        end else if (flush) begin
            // pc is left alone on flush; only the word and valid are cleared
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end else if (load) begin
            instr_reg <= instr_in;
            pc_reg    <= pc_in;
            valid_reg <= 1'b1;
        end else if (consume) begin
            valid_reg <= 1'b0;
        end
    end

    assign instr = instr_reg;
    assign pc    = pc_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the multicycle processor.
// Keeps the PC, issues one outstanding request at a time to instruction
// memory, captures the returned word into the IF/ID register and splits it
// into the fields the controller decodes.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   stall                 downstream cannot take the IF/ID instruction
//   redirect, redirect_pc taken branch/jump and its target
//   imem_req/addr         request to instruction memory
//   imem_ready/rdata      response (same cycle as the request address)
//   ihit                  IF/ID holds a valid instruction
//   pc_d, instr_d         PC and raw word of the IF/ID instruction
//   opcode..rs2           field slices of instr_d
//   fetch_count           delivered instructions (wrapping)
//   wait_cycles           FETCH cycles without imem_ready (saturating)
module fetch_stage
    import proc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            ihit,
    output logic [XLEN-1:0] pc_d,
    output logic [31:0]     instr_d,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [31:0]     fetch_count,
    output logic [31:0]     wait_cycles
);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [31:0]     fetch_count_reg, fetch_count_next;
    logic [31:0]     wait_cycles_reg, wait_cycles_next;
    logic            ifid_load, ifid_consume, ifid_flush;
    logic            ifid_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_PC;
            fetch_count_reg <= '0;
            wait_cycles_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            fetch_count_reg <= fetch_count_next;
            wait_cycles_reg <= wait_cycles_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        fetch_count_next = fetch_count_reg;
        wait_cycles_next = wait_cycles_reg;
        ifid_load        = 1'b0;
        ifid_consume     = 1'b0;
        ifid_flush       = 1'b0;

        if (redirect) begin
            // Redirect wins over stall and over a same-edge memory response,
            // which is simply dropped.
            pc_next    = {redirect_pc[XLEN-1:2], 2'b00};
            ifid_flush = 1'b1;
            state_next = FETCH;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem_ready) begin
                        ifid_load        = 1'b1;
                        pc_next          = pc_reg + XLEN'(4);
                        fetch_count_next = fetch_count_reg + 32'd1;
                        state_next       = DECODE;
                    end else if (wait_cycles_reg != '1) begin
                        wait_cycles_next = wait_cycles_reg + 32'd1;
                    end
                end
                DECODE: begin
                    if (!stall) begin
                        ifid_consume = 1'b1;
                        state_next   = FETCH;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
    end

    ifid_reg #(
        .XLEN(XLEN)
    ) u_ifid (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load),
        .consume  (ifid_consume),
        .flush    (ifid_flush),
        .instr_in (imem_rdata),
        .pc_in    (pc_reg),
        .instr    (instr_d),
        .pc       (pc_d),
        .valid    (ifid_valid)
    );

    // The state register sits at FETCH throughout reset, so the request is
    // gated by reset itself to drop immediately when reset is asserted.
    assign imem_req    = (state_reg == FETCH) && reset;
    assign imem_addr   = pc_reg;
    assign ihit        = ifid_valid;
    assign fetch_count = fetch_count_reg;
    assign wait_cycles = wait_cycles_reg;

    assign opcode = instr_d[6:0];
    assign rd     = instr_d[11:7];
    assign funct3 = instr_d[14:12];
    assign rs1    = instr_d[19:15];
    assign rs2    = instr_d[24:20];
    assign funct7 = instr_d[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ihit;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] fetch_count;
    logic [31:0] wait_cycles;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .ihit        (ihit),
        .pc_d        (pc_d),
        .instr_d     (instr_d),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .fetch_count (fetch_count),
        .wait_cycles (wait_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pc = 32'h0000_1000;
    logic [31:0] exp_fc = 0;
    logic [31:0] held_pc, held_instr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the IF/ID contents against the oldest accepted response.
    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_underflow observed=ihit expected=no_instruction");
        end else begin
            e = sb.pop_front();
            check("pc_d", pc_d, e.pc);
            check("instr_d", instr_d, e.instr);
            check("opcode", {25'd0, opcode}, {25'd0, e.instr[6:0]});
            check("rd", {27'd0, rd}, {27'd0, e.instr[11:7]});
            check("funct3", {29'd0, funct3}, {29'd0, e.instr[14:12]});
            check("rs1", {27'd0, rs1}, {27'd0, e.instr[19:15]});
            check("rs2", {27'd0, rs2}, {27'd0, e.instr[24:20]});
            check("funct7", {25'd0, funct7}, {25'd0, e.instr[31:25]});
            check("fetch_count", fetch_count, exp_fc);
            $display("txn pc=%h instr=%h fetch_count=%0d", pc_d, instr_d, fetch_count);
        end
    endtask

    // Entered just after a negedge in FETCH; returns at the negedge where
    // the instruction is visible in IF/ID.
    task automatic do_fetch(input logic [31:0] word, input int delay);
        for (int i = 0; i < delay; i++) begin
            check("req_wait", {31'd0, imem_req}, 32'd1);
            check("ihit_wait", {31'd0, ihit}, 32'd0);
            imem_ready = 1'b0;
            @(negedge clk);
        end
        check("req_ready", {31'd0, imem_req}, 32'd1);
        check("imem_addr", imem_addr, exp_pc);
        imem_ready = 1'b1;
        imem_rdata = word;
        sb.push_back({exp_pc, word});
        exp_pc = exp_pc + 32'd4;
        exp_fc = exp_fc + 32'd1;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check("ihit_decode", {31'd0, ihit}, 32'd1);
        check("req_decode", {31'd0, imem_req}, 32'd0);
        pop_check();
    endtask

    task automatic consume();
        stall = 1'b0;
        @(negedge clk);
        check("ihit_consumed", {31'd0, ihit}, 32'd0);
        check("req_next", {31'd0, imem_req}, 32'd1);
        check("next_addr", imem_addr, exp_pc);
    endtask

    initial begin
        // Reset values
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_ihit", {31'd0, ihit}, 32'd0);
        check("rst_instr", instr_d, 32'h0000_0013);
        check("rst_pc_d", pc_d, 32'd0);
        check("rst_addr", imem_addr, 32'h0000_1000);
        check("rst_fc", fetch_count, 32'd0);
        check("rst_wc", wait_cycles, 32'd0);

        // Basic fetch, immediate ready
        @(negedge clk);
        reset = 1'b1;
        #1;
        do_fetch(32'h0050_0093, 0);
        check("t1_opcode", {25'd0, opcode}, 32'h13);
        check("t1_rd", {27'd0, rd}, 32'd1);
        consume();
        check("t1_next_addr", imem_addr, 32'h0000_1004);

        // Ready delayed three cycles
        do_fetch(32'h0020_81b3, 3);
        check("t2_wait_cycles", wait_cycles, 32'd3);
        consume();

        // Stall held for five cycles
        do_fetch(32'h4031_5233, 0);
        held_pc = pc_d;
        held_instr = instr_d;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ihit", {31'd0, ihit}, 32'd1);
            check("stall_pc_d", pc_d, held_pc);
            check("stall_instr", instr_d, held_instr);
            check("stall_req", {31'd0, imem_req}, 32'd0);
        end
        consume();
        check("stall_resume_addr", imem_addr, held_pc + 32'd4);

        // Redirect on the same edge as a memory response
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0073;
        redirect = 1'b1;
        redirect_pc = 32'h0000_2002;
        @(negedge clk);
        redirect = 1'b0;
        imem_ready = 1'b0;
        exp_pc = 32'h0000_2000;
        check("redir_ihit", {31'd0, ihit}, 32'd0);
        check("redir_addr", imem_addr, 32'h0000_2000);
        check("redir_fc", fetch_count, exp_fc);
        check("redir_instr", instr_d, 32'h0000_0013);
        do_fetch(32'h0080_0513, 0);

        // Redirect while stalled in DECODE still flushes
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        stall = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        check("rs_ihit", {31'd0, ihit}, 32'd0);
        check("rs_instr", instr_d, 32'h0000_0013);
        check("rs_addr", imem_addr, 32'hFFFF_FFFC);

        // PC wrap at the top of the address space
        do_fetch(32'h0000_0fb7, 0);
        consume();
        check("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset asserted mid-fetch with a pending ready
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5013;
        #2 reset = 1'b0;
        #1;
        check("mrst_req", {31'd0, imem_req}, 32'd0);
        check("mrst_ihit", {31'd0, ihit}, 32'd0);
        check("mrst_instr", instr_d, 32'h0000_0013);
        check("mrst_pc_d", pc_d, 32'd0);
        check("mrst_fc", fetch_count, 32'd0);
        check("mrst_wc", wait_cycles, 32'd0);
        @(negedge clk);
        check("mrst_hold_ihit", {31'd0, ihit}, 32'd0);
        check("mrst_hold_addr", imem_addr, 32'h0000_1000);
        imem_ready = 1'b0;
        reset = 1'b1;
        #1;
        exp_pc = 32'h0000_1000;
        exp_fc = 0;
        do_fetch(32'h00c0_0593, 1);
        consume();

        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
